// File: rtl/comb_wb_regs.sv
// rtl/comb_wb_regs.sv - Wishbone register file and access sequencer for the combination core
module comb_wb_regs #(
    parameter int CHANNELS       = 16,
    parameter int CHANNEL_WIDTH  = 4,
    parameter int LUT_ADDR_WIDTH = 6,
    parameter int TIMEOUT        = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wb_cyc_i,
    input  logic                             wb_stb_i,
    input  logic                             wb_we_i,
    input  logic [7:0]                       wb_adr_i,
    input  logic [31:0]                      wb_dat_i,
    output logic [31:0]                      wb_dat_o,
    output logic                             wb_ack_o,
    output logic [63:0]                      window,
    output logic [$clog2(CHANNELS+1)-1:0]    filter_min,
    output logic [$clog2(CHANNELS+1)-1:0]    filter_max,
    output logic [1:0]                       select_comb_fifo,
    output logic                             capture_enable,
    output logic                             start_reading,
    output logic                             reset_comb,
    input  logic                             reset_comb_done,
    output logic [1:0]                       lut_WrRd,
    output logic [LUT_ADDR_WIDTH-1:0]        lut_addr,
    output logic [CHANNEL_WIDTH:0]           lut_dat_i,
    input  logic [CHANNEL_WIDTH:0]           lut_dat_o,
    input  logic                             lut_ack,
    output logic                             ready_i,
    input  logic                             comb_out_vd,
    input  logic [31:0]                      comb_count
);
    localparam int FW = $clog2(CHANNELS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [31:0]   ID_WORD  = 32'h636F6D62;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LUT, S_RES, S_RST, S_ACK} state_t;
    state_t state, next_state;

    logic [TW-1:0]          tmo_cnt;
    logic [31:0]            dat_q;
    logic [31:0]            rd_mux;
    logic                   lut_err;
    logic [CHANNEL_WIDTH:0] lut_rdata;
    logic                   req;
    logic                   go_reg, go_rst, go_lut, go_res;
    logic                   lut_done, lut_tmo, res_done, res_tmo;

    assign req      = wb_cyc_i & wb_stb_i;
    // ack is dropped if the master abandoned the cycle while a slow access finished
    assign wb_ack_o = wb_cyc_i && (state == S_ACK || state == S_RST);
    assign ready_i  = (state == S_RES);
    assign wb_dat_o = dat_q;

    always_comb begin
        next_state = state;
        go_reg     = 1'b0;
        go_rst     = 1'b0;
        go_lut     = 1'b0;
        go_res     = 1'b0;
        lut_done   = 1'b0;
        lut_tmo    = 1'b0;
        res_done   = 1'b0;
        res_tmo    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (wb_we_i && wb_adr_i == 8'h07 && wb_dat_i[0]) begin
                        go_rst     = 1'b1;
                        next_state = S_RST;
                    end else if (wb_we_i && wb_adr_i == 8'h08) begin
                        if (!reset_comb) begin
                            go_lut     = 1'b1;
                            next_state = S_LUT;
                        end
                    end else if (!wb_we_i && wb_adr_i == 8'h0F) begin
                        if (!reset_comb) begin
                            if (start_reading) begin
                                go_res     = 1'b1;
                                next_state = S_RES;
                            end else begin
                                go_reg     = 1'b1;
                                next_state = S_ACK;
                            end
                        end
                    end else begin
                        go_reg     = 1'b1;
                        next_state = S_ACK;
                    end
                end
            end
            S_LUT: begin
                if (lut_ack) begin
                    lut_done   = 1'b1;
                    next_state = S_ACK;
                end else if (tmo_cnt == TMO_LAST) begin
                    lut_tmo    = 1'b1;
                    next_state = S_ACK;
                end
            end
            S_RES: begin
                if (comb_out_vd) begin
                    res_done   = 1'b1;
                    next_state = S_ACK;
                end else if (tmo_cnt == TMO_LAST) begin
                    res_tmo    = 1'b1;
                    next_state = S_ACK;
                end
            end
            S_RST:   next_state = S_IDLE;
            S_ACK:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        rd_mux = '0;
        case (wb_adr_i)
            8'h00:   rd_mux = ID_WORD;
            8'h01:   rd_mux = window[31:0];
            8'h02:   rd_mux = window[63:32];
            8'h03:   rd_mux = {{(16-FW){1'b0}}, filter_max, {(16-FW){1'b0}}, filter_min};
            8'h04:   rd_mux = {30'h0, select_comb_fifo};
            8'h05:   rd_mux = {31'h0, capture_enable};
            8'h06:   rd_mux = {31'h0, start_reading};
            8'h07:   rd_mux = {31'h0, reset_comb};
            8'h08:   rd_mux = {lut_err, 15'h0, lut_rdata[CHANNEL_WIDTH],
                               {(15-CHANNEL_WIDTH){1'b0}}, lut_rdata[CHANNEL_WIDTH-1:0]};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt          <= '0;
            dat_q            <= '0;
            window           <= '0;
            filter_min       <= '0;
            filter_max       <= FW'(CHANNELS);
            select_comb_fifo <= 2'b10;
            capture_enable   <= 1'b0;
            start_reading    <= 1'b0;
            reset_comb       <= 1'b0;
            lut_WrRd         <= 2'b00;
            lut_addr         <= '0;
            lut_dat_i        <= '0;
            lut_rdata        <= '0;
            lut_err          <= 1'b0;
        end else begin
            if (go_lut || go_res)
                tmo_cnt <= '0;
            else if (state == S_LUT || state == S_RES)
                tmo_cnt <= tmo_cnt + TW'(1);

            if (go_reg) begin
                dat_q <= wb_we_i ? 32'h0 : rd_mux;
                if (wb_we_i) begin
                    case (wb_adr_i)
                        8'h01: window[31:0]     <= wb_dat_i;
                        8'h02: window[63:32]    <= wb_dat_i;
                        8'h03: begin
                            filter_max <= wb_dat_i[16 +: FW];
                            filter_min <= wb_dat_i[FW-1:0];
                        end
                        8'h04: select_comb_fifo <= wb_dat_i[1:0];
                        8'h05: capture_enable   <= wb_dat_i[0];
                        8'h06: start_reading    <= wb_dat_i[0];
                        default: ;
                    endcase
                end
            end

            // a new reset request wins over a completion seen in the same cycle
            if (go_rst) begin
                reset_comb     <= 1'b1;
                capture_enable <= 1'b0;
                dat_q          <= '0;
            end else if (reset_comb && reset_comb_done) begin
                reset_comb <= 1'b0;
            end

            if (go_lut) begin
                lut_WrRd  <= (wb_dat_i[31:30] == 2'b10) ? 2'b10 : 2'b01;
                lut_addr  <= wb_dat_i[16 +: LUT_ADDR_WIDTH];
                lut_dat_i <= {wb_dat_i[15], wb_dat_i[CHANNEL_WIDTH-1:0]};
                dat_q     <= '0;
            end
            if (lut_done) begin
                if (lut_WrRd == 2'b01) lut_rdata <= lut_dat_o;
                lut_err  <= 1'b0;
                lut_WrRd <= 2'b00;
            end
            if (lut_tmo) begin
                lut_err  <= 1'b1;
                lut_WrRd <= 2'b00;
            end

            if (res_done) dat_q <= comb_count;
            if (res_tmo)  dat_q <= 32'hFFFF_FFFF;
        end
    end
endmodule

// File: tb/tb_comb_wb_regs.sv
// tb/tb_comb_wb_regs.sv - self-checking bench for comb_wb_regs
module tb_comb_wb_regs;
    localparam int CHANNELS = 16;
    localparam int CW       = 4;
    localparam int LAW      = 6;
    localparam int TIMEOUT  = 1024;
    localparam int FW       = $clog2(CHANNELS + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [7:0]    wb_adr_i = '0;
    logic [31:0]   wb_dat_i = '0;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic [63:0]   window;
    logic [FW-1:0] filter_min, filter_max;
    logic [1:0]    select_comb_fifo;
    logic          capture_enable, start_reading, reset_comb;
    logic          reset_comb_done = 1'b0;
    logic [1:0]    lut_WrRd;
    logic [LAW-1:0] lut_addr;
    logic [CW:0]   lut_dat_i;
    logic [CW:0]   lut_dat_o = '0;
    logic          lut_ack = 1'b0;
    logic          ready_i;
    logic          comb_out_vd = 1'b0;
    logic [31:0]   comb_count = '0;

    comb_wb_regs #(.CHANNELS(CHANNELS), .CHANNEL_WIDTH(CW), .LUT_ADDR_WIDTH(LAW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .window(window), .filter_min(filter_min), .filter_max(filter_max),
        .select_comb_fifo(select_comb_fifo), .capture_enable(capture_enable),
        .start_reading(start_reading), .reset_comb(reset_comb), .reset_comb_done(reset_comb_done),
        .lut_WrRd(lut_WrRd), .lut_addr(lut_addr), .lut_dat_i(lut_dat_i), .lut_dat_o(lut_dat_o),
        .lut_ack(lut_ack), .ready_i(ready_i), .comb_out_vd(comb_out_vd), .comb_count(comb_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Register-map reference model
    logic [63:0] mdl_win;
    int mdl_fmin, mdl_fmax, mdl_sel, mdl_cap, mdl_start;

    function automatic void mdl_reset();
        mdl_win = '0; mdl_fmin = 0; mdl_fmax = CHANNELS; mdl_sel = 2; mdl_cap = 0; mdl_start = 0;
    endfunction

    function automatic void mdl_write(input int adr, input logic [31:0] d);
        case (adr)
            1: mdl_win[31:0]  = d;
            2: mdl_win[63:32] = d;
            3: begin
                mdl_fmax = int'((d >> 16) % (1 << FW));
                mdl_fmin = int'((d & 32'hFFFF) % (1 << FW));
            end
            4: mdl_sel   = int'(d % 4);
            5: mdl_cap   = int'(d % 2);
            6: mdl_start = int'(d % 2);
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] mdl_read(input int adr);
        case (adr)
            0: return 32'h636F6D62;
            1: return mdl_win[31:0];
            2: return mdl_win[63:32];
            3: return 32'(mdl_fmax * 65536 + mdl_fmin);
            4: return 32'(mdl_sel);
            5: return 32'(mdl_cap);
            6: return 32'(mdl_start);
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk_outputs(input string tag);
        chk({tag, "_window"}, window, mdl_win);
        chk({tag, "_fmin"}, 64'(filter_min), 64'(mdl_fmin));
        chk({tag, "_fmax"}, 64'(filter_max), 64'(mdl_fmax));
        chk({tag, "_sel"}, 64'(select_comb_fifo), 64'(mdl_sel));
        chk({tag, "_cap"}, 64'(capture_enable), 64'(mdl_cap));
        chk({tag, "_start"}, 64'(start_reading), 64'(mdl_start));
    endtask

    // LUT responder: acks after lut_delay waiting cycles, snapshots the request
    logic [CW:0]  lut_mem [0:63];
    int           lut_delay = 3;
    int           lut_wait = 0;
    logic         lut_en = 1'b1;
    logic [1:0]   snap_op = '0;
    logic [LAW-1:0] snap_addr = '0;
    logic [CW:0]  snap_dat = '0;

    initial for (int i = 0; i < 64; i++) lut_mem[i] = '0;

    always begin
        @(negedge clk);
        if (lut_ack) begin
            lut_ack = 1'b0;
        end else if (lut_en && lut_WrRd != 2'b00) begin
            if (lut_wait == 0) begin
                snap_op = lut_WrRd; snap_addr = lut_addr; snap_dat = lut_dat_i;
            end
            if (lut_wait >= lut_delay) begin
                lut_ack  = 1'b1;
                lut_wait = 0;
                if (lut_WrRd == 2'b10) lut_mem[lut_addr] = lut_dat_i;
                else                   lut_dat_o = lut_mem[lut_addr];
            end else begin
                lut_wait++;
            end
        end else begin
            lut_wait = 0;
        end
    end

    // Result source: each word is offered after its gap of idle cycles
    typedef struct { logic [31:0] word; int gap; } res_t;
    res_t res_q[$];
    int   res_gap = 0;
    int   hs_cnt = 0;
    logic hs_pend = 1'b0;

    always begin
        @(negedge clk);
        if (hs_pend) begin
            res_q.delete(0);
            comb_out_vd = 1'b0; hs_pend = 1'b0; res_gap = 0;
        end
        if (!comb_out_vd && res_q.size() > 0) begin
            if (res_gap >= res_q[0].gap) begin
                comb_out_vd = 1'b1; comb_count = res_q[0].word;
            end else begin
                res_gap++;
            end
        end
        if (comb_out_vd && ready_i) begin
            hs_pend = 1'b1; hs_cnt++;
        end
    end

    task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                           input int budget, output logic [31:0] rd, output int lat);
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!wb_ack_o && lat < budget);
        chk($sformatf("ack_seen_%0h", adr), 64'(wb_ack_o), 64'd1);
        rd = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
        chk($sformatf("ack_one_cycle_%0h", adr), 64'(wb_ack_o), 64'd0);
    endtask

    typedef struct { logic we; logic [7:0] adr; logic [31:0] wdat; logic [31:0] exp; logic cmp; string name; } vec_t;
    vec_t rst_vecs[$];
    vec_t plan_vecs[$];
    vec_t edge_vecs[$];

    function automatic vec_t mk(input logic we, input logic [7:0] adr, input logic [31:0] wdat,
                                input logic [31:0] exp, input string name);
        vec_t v;
        v.we = we; v.adr = adr; v.wdat = wdat; v.exp = exp; v.cmp = !we; v.name = name;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v);
        logic [31:0] rd;
        int lat;
        wb_xfer(v.we, v.adr, v.wdat, 20, rd, lat);
        chk({v.name, "_lat"}, 64'(lat), 64'd1);
        if (v.cmp) chk(v.name, 64'(rd), 64'(v.exp));
        if (v.we) mdl_write(int'(v.adr), v.wdat);
    endtask

    task automatic chk_reset_pins(input string tag);
        chk({tag, "_reset_comb"}, 64'(reset_comb), 64'd0);
        chk({tag, "_lut_WrRd"}, 64'(lut_WrRd), 64'd0);
        chk({tag, "_ready_i"}, 64'(ready_i), 64'd0);
        chk({tag, "_ack"}, 64'(wb_ack_o), 64'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int lat, a, hs0;
        logic w;
        logic [31:0] d;
        logic [5:0] la;
        logic [3:0] ch;
        logic v;
        logic [7:0] junk;
        logic [CW:0] exp_lut [0:63];
        logic [5:0] la_list[$];
        logic [31:0] exp_words[$];

        for (int i = 0; i < 64; i++) exp_lut[i] = '0;

        rst_vecs.push_back(mk(0, 8'h00, 0, 32'h636F6D62, "rst_id"));
        rst_vecs.push_back(mk(0, 8'h03, 0, 32'h00100000, "rst_filter"));
        rst_vecs.push_back(mk(0, 8'h04, 0, 32'h00000002, "rst_select"));
        rst_vecs.push_back(mk(0, 8'h01, 0, 32'h0, "rst_win_lo"));
        rst_vecs.push_back(mk(0, 8'h06, 0, 32'h0, "rst_start"));

        plan_vecs.push_back(mk(1, 8'h01, 32'h32, 0, "wr_win_lo"));
        plan_vecs.push_back(mk(1, 8'h02, 32'h0, 0, "wr_win_hi"));
        plan_vecs.push_back(mk(1, 8'h03, 32'h00100000, 0, "wr_filter"));
        plan_vecs.push_back(mk(0, 8'h01, 0, 32'h32, "rd_win_lo"));
        plan_vecs.push_back(mk(0, 8'h02, 0, 32'h0, "rd_win_hi"));
        plan_vecs.push_back(mk(0, 8'h03, 0, 32'h00100000, "rd_filter"));

        edge_vecs.push_back(mk(1, 8'h03, 32'hFFFFFFFF, 0, "wr_filter_ones"));
        edge_vecs.push_back(mk(0, 8'h03, 0, 32'h001F001F, "rd_filter_trunc"));
        edge_vecs.push_back(mk(1, 8'h00, 32'h12345678, 0, "wr_id"));
        edge_vecs.push_back(mk(0, 8'h00, 0, 32'h636F6D62, "rd_id_ro"));
        edge_vecs.push_back(mk(1, 8'h04, 32'hFFFFFFFD, 0, "wr_sel"));
        edge_vecs.push_back(mk(0, 8'h04, 0, 32'h1, "rd_sel"));
        edge_vecs.push_back(mk(0, 8'h09, 0, 32'h0, "rd_unmapped9"));
        edge_vecs.push_back(mk(1, 8'h0A, 32'hFFFFFFFF, 0, "wr_unmappedA"));
        edge_vecs.push_back(mk(0, 8'h0A, 0, 32'h0, "rd_unmappedA"));
        edge_vecs.push_back(mk(0, 8'h0F, 0, 32'h0, "rd_result_idle"));
        edge_vecs.push_back(mk(0, 8'h07, 0, 32'h0, "rd_rst_idle"));
        edge_vecs.push_back(mk(0, 8'h08, 0, 32'h0, "rd_lut_idle"));
        edge_vecs.push_back(mk(1, 8'h04, 32'h2, 0, "wr_sel_hist"));
        edge_vecs.push_back(mk(1, 8'h03, 32'h00100000, 0, "wr_filter_back"));

        #2 rst_n = 1'b0;
        mdl_reset();
        repeat (3) @(negedge clk);
        chk_outputs("por");
        chk_reset_pins("por");
        rst_n = 1'b1;

        foreach (rst_vecs[i]) apply_vec(rst_vecs[i]);
        foreach (plan_vecs[i]) apply_vec(plan_vecs[i]);
        chk("plan_window", window, 64'h32);
        chk("plan_fmax", 64'(filter_max), 64'd16);
        chk("plan_fmin", 64'(filter_min), 64'd0);
        foreach (edge_vecs[i]) apply_vec(edge_vecs[i]);
        chk_outputs("edge");

        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 14));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (a == 8) a = 9;
            if (a == 7) w = 1'b0;
            wb_xfer(w, 8'(a), d, 20, rd, lat);
            if (w) mdl_write(a, d);
            else   chk($sformatf("rand_rd_%0h", a), 64'(rd), 64'(mdl_read(a)));
        end
        chk_outputs("rand");

        lut_delay = 3;
        wb_xfer(1, 8'h08, 32'h8005_8004, 50, rd, lat);
        chk("lut_wr_op", 64'(snap_op), 64'h2);
        chk("lut_wr_addr", 64'(snap_addr), 64'd5);
        chk("lut_wr_dat", 64'(snap_dat), 64'b10100);
        chk("lut_wr_lat", 64'(lat), 64'(lut_delay + 2));
        chk("lut_wrrd_clear", 64'(lut_WrRd), 64'd0);
        wb_xfer(1, 8'h08, 32'h0005_0000, 50, rd, lat);
        chk("lut_rd_op", 64'(snap_op), 64'h1);
        wb_xfer(0, 8'h08, 0, 20, rd, lat);
        chk("lut_readback", 64'(rd), 64'h00008004);
        exp_lut[5] = 5'b10100;

        for (int i = 0; i < 6; i++) begin
            la = 6'($urandom_range(0, 63)); ch = 4'($urandom_range(0, 15));
            v = 1'($urandom_range(0, 1)); junk = 8'($urandom_range(0, 255));
            lut_delay = int'($urandom_range(0, 5));
            wb_xfer(1, 8'h08, {2'b10, junk, la, v, 11'h0, ch}, 50, rd, lat);
            exp_lut[la] = {v, ch};
            la_list.push_back(la);
        end
        foreach (la_list[i]) begin
            junk = 8'($urandom_range(0, 255));
            wb_xfer(1, 8'h08, {2'b01, junk, la_list[i], 16'h0}, 50, rd, lat);
            wb_xfer(0, 8'h08, 0, 20, rd, lat);
            chk($sformatf("lut_rand_%0d", la_list[i]), 64'(rd),
                64'({16'h0, exp_lut[la_list[i]][CW], 11'h0, exp_lut[la_list[i]][CW-1:0]}));
        end

        wb_xfer(1, 8'h06, 32'h1, 20, rd, lat);
        mdl_write(6, 32'h1);
        hs0 = hs_cnt;
        res_q.push_back('{32'h11, 0});
        res_q.push_back('{32'h22, 4});
        wb_xfer(0, 8'h0F, 0, 100, rd, lat);
        chk("res_word0", 64'(rd), 64'h11);
        wb_xfer(0, 8'h0F, 0, 100, rd, lat);
        chk("res_word1", 64'(rd), 64'h22);
        chk("res_hs_count", 64'(hs_cnt - hs0), 64'd2);
        chk("res_ready_low", 64'(ready_i), 64'd0);

        hs0 = hs_cnt;
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            res_q.push_back('{d, int'($urandom_range(0, 6))});
            exp_words.push_back(d);
        end
        foreach (exp_words[i]) begin
            wb_xfer(0, 8'h0F, 0, 100, rd, lat);
            chk($sformatf("res_rand_%0d", i), 64'(rd), 64'(exp_words[i]));
        end
        repeat (3) @(negedge clk);
        chk("res_rand_hs", 64'(hs_cnt - hs0), 64'd5);
        chk("res_ready_idle", 64'(ready_i), 64'd0);

        wb_xfer(1, 8'h05, 32'h1, 20, rd, lat);
        mdl_write(5, 32'h1);
        chk("cap_set", 64'(capture_enable), 64'd1);
        wb_xfer(1, 8'h07, 32'h1, 20, rd, lat);
        chk("rst_req_lat", 64'(lat), 64'd1);
        chk("rst_cap_drop", 64'(capture_enable), 64'd0);
        chk("rst_busy", 64'(reset_comb), 64'd1);
        mdl_cap = 0;
        wb_xfer(0, 8'h07, 0, 20, rd, lat);
        chk("rst_rd_busy", 64'(rd), 64'd1);
        repeat (6) @(negedge clk);
        reset_comb_done = 1'b1;
        chk("rst_hold_at_done", 64'(reset_comb), 64'd1);
        @(negedge clk);
        chk("rst_clear_after_done", 64'(reset_comb), 64'd0);
        reset_comb_done = 1'b0;
        wb_xfer(0, 8'h07, 0, 20, rd, lat);
        chk("rst_rd_idle", 64'(rd), 64'd0);

        hs0 = hs_cnt;
        wb_xfer(0, 8'h0F, 0, TIMEOUT + 50, rd, lat);
        chk("res_tmo_data", 64'(rd), 64'hFFFFFFFF);
        chk_rng("res_tmo_lat", lat, TIMEOUT, TIMEOUT + 2);
        chk("res_tmo_no_hs", 64'(hs_cnt - hs0), 64'd0);

        lut_en = 1'b0;
        wb_xfer(1, 8'h08, 32'h0003_0000, TIMEOUT + 50, rd, lat);
        chk_rng("lut_tmo_lat", lat, TIMEOUT, TIMEOUT + 2);
        chk("lut_tmo_clear", 64'(lut_WrRd), 64'd0);
        wb_xfer(0, 8'h08, 0, 20, rd, lat);
        chk("lut_tmo_err", 64'(rd[31]), 64'd1);
        lut_en = 1'b1;

        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h0F;
        repeat (4) @(negedge clk);
        chk("midres_ready", 64'(ready_i), 64'd1);
        rst_n = 1'b0;
        #1;
        mdl_reset();
        chk_reset_pins("midres");
        chk_outputs("midres");
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        foreach (rst_vecs[i]) apply_vec(rst_vecs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
